// File: rtl/tow_game_ctrl.sv
// Tug-Of-War round sequencer: IDLE -> countdown -> play -> win blink, timed by slowen ticks.
// Optional macro TOW_FALSE_START_EN: presses during countdown push the rope away from the presser.
module tow_game_ctrl #(
  parameter int NPOS        = 9,
  parameter int CNTDN_TICKS = 4,
  parameter int WIN_TICKS   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slowen,
  input  logic            start,
  input  logic            btn_l,
  input  logic            btn_r,
  output logic            div_rst,
  output logic [NPOS-1:0] leds,
  output logic [1:0]      winner,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CNTDN = 2'b01,
    PLAY  = 2'b10,
    WIN   = 2'b11
  } state_t;

  localparam int              PW          = $clog2(NPOS);
  localparam logic [PW-1:0]   CENTRE      = PW'((NPOS - 1) / 2);
  localparam logic [PW-1:0]   LAST        = PW'(NPOS - 1);
  localparam logic [NPOS-1:0] ONE         = NPOS'(1);
  localparam logic [NPOS-1:0] LEDS_CENTRE = ONE << CENTRE;

  state_t            st_q, st_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [7:0]        tick_q, tick_d;
  logic              blank_q, blank_d;
  logic [1:0]        winner_d;
  logic              div_rst_d;
  logic [NPOS-1:0]   leds_d;
  logic              tick_last;

  assign state     = st_q;
  assign tick_last = (tick_q == 8'd1);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    st_d      = st_q;
    pos_d     = pos_q;
    tick_d    = tick_q;
    blank_d   = blank_q;
    winner_d  = winner;
    div_rst_d = 1'b0;
    case (st_q)
      IDLE: begin
        if (start) begin
          st_d      = CNTDN;
          tick_d    = 8'(CNTDN_TICKS);
          div_rst_d = 1'b1;
          pos_d     = CENTRE;
        end
      end
      CNTDN: begin
        // A tick seen while div_rst is high was issued before the divider restarted.
        if (slowen && !div_rst) begin
          tick_d = tick_q - 8'd1;
          if (tick_last) st_d = PLAY;
        end
`ifdef TOW_FALSE_START_EN
        if (btn_l && !btn_r && pos_q < PW'(NPOS - 2)) pos_d = pos_q + PW'(1);
        else if (btn_r && !btn_l && pos_q > PW'(1))   pos_d = pos_q - PW'(1);
`endif
      end
      PLAY: begin
        if (btn_l ^ btn_r) begin
          pos_d = btn_l ? pos_q - PW'(1) : pos_q + PW'(1);
          if (pos_d == '0 || pos_d == LAST) begin
            st_d     = WIN;
            winner_d = (pos_d == '0) ? 2'b01 : 2'b10;
            tick_d   = 8'(WIN_TICKS);
            blank_d  = 1'b0;
          end
        end
      end
      WIN: begin
        if (slowen) begin
          blank_d = !blank_q;
          tick_d  = tick_q - 8'd1;
          if (tick_last) begin
            st_d     = IDLE;
            pos_d    = CENTRE;
            winner_d = 2'b00;
            blank_d  = 1'b0;
          end
        end
      end
      default: st_d = IDLE;
    endcase
    leds_d = blank_d ? '0 : (ONE << pos_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      pos_q   <= CENTRE;
      tick_q  <= 8'd0;
      blank_q <= 1'b0;
      winner  <= 2'b00;
      div_rst <= 1'b0;
      leds    <= LEDS_CENTRE;
    end else begin
      st_q    <= st_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      blank_q <= blank_d;
      winner  <= winner_d;
      div_rst <= div_rst_d;
      leds    <= leds_d;
    end
  end

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Directed self-checking bench for tow_game_ctrl (NPOS=9, CNTDN_TICKS=4, WIN_TICKS=8).
module tb_tow_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       slowen = 1'b0;
  logic       start = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic       div_rst;
  logic [8:0] leds;
  logic [1:0] winner;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  tow_game_ctrl #(.NPOS(9), .CNTDN_TICKS(4), .WIN_TICKS(8)) dut (
    .clk(clk), .rst(rst), .slowen(slowen), .start(start),
    .btn_l(btn_l), .btn_r(btn_r), .div_rst(div_rst),
    .leds(leds), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_play();
    start = 1'b1; step(); start = 1'b0;
    step();
    repeat (4) begin
      slowen = 1'b1; step(); slowen = 1'b0; step();
    end
    n_checks++;
    if (state !== 2'b10) begin n_fail++; $display("FAIL go_play state: got %b want 10", state); end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_checks++;
    if (state !== 2'b00) begin n_fail++; $display("FAIL reset state: got %b want 00", state); end
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL reset leds: got %h want 010", leds); end
    n_checks++;
    if (winner !== 2'b00) begin n_fail++; $display("FAIL reset winner: got %b want 00", winner); end
    n_checks++;
    if (div_rst !== 1'b0) begin n_fail++; $display("FAIL reset div_rst: got %b want 0", div_rst); end
    btn_l = 1'b1; step(); btn_l = 1'b0;
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL idle btn leds: got %h want 010", leds); end
  endtask

  task automatic test_countdown();
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL cntdn entry state: got %b want 01", state); end
    n_checks++;
    if (div_rst !== 1'b1) begin n_fail++; $display("FAIL cntdn div_rst high: got %b want 1", div_rst); end
    // Tick coinciding with div_rst must not count.
    slowen = 1'b1; step(); slowen = 1'b0;
    n_checks++;
    if (div_rst !== 1'b0) begin n_fail++; $display("FAIL cntdn div_rst pulse width: got %b want 0", div_rst); end
    for (int k = 1; k <= 4; k++) begin
      step();
      slowen = 1'b1; step(); slowen = 1'b0;
      n_checks++;
      if (state !== ((k == 4) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL cntdn tick %0d state: got %b want %b", k, state, (k == 4) ? 2'b10 : 2'b01);
      end
    end
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL play entry leds: got %h want 010", leds); end
  endtask

  task automatic test_left_win();
    logic [8:0] exp_walk [4];
    logic [8:0] exp_led;
    exp_walk = '{9'h008, 9'h004, 9'h002, 9'h001};
    for (int k = 0; k < 4; k++) begin
      btn_l = 1'b1; step(); btn_l = 1'b0;
      n_checks++;
      if (leds !== exp_walk[k]) begin n_fail++; $display("FAIL left walk %0d leds: got %h want %h", k, leds, exp_walk[k]); end
      step();
    end
    n_checks++;
    if (state !== 2'b11) begin n_fail++; $display("FAIL left win state: got %b want 11", state); end
    n_checks++;
    if (winner !== 2'b01) begin n_fail++; $display("FAIL left win winner: got %b want 01", winner); end
    btn_r = 1'b1; start = 1'b1; step(); btn_r = 1'b0; start = 1'b0;
    n_checks++;
    if (leds !== 9'h001 || state !== 2'b11) begin
      n_fail++; $display("FAIL win ignores input: leds %h state %b want 001 11", leds, state);
    end
    for (int k = 1; k <= 8; k++) begin
      slowen = 1'b1; step(); slowen = 1'b0;
      exp_led = (k == 8) ? 9'h010 : ((k % 2 == 1) ? 9'h000 : 9'h001);
      n_checks++;
      if (leds !== exp_led) begin n_fail++; $display("FAIL blink tick %0d leds: got %h want %h", k, leds, exp_led); end
      if (k >= 7) begin
        n_checks++;
        if (state !== ((k == 8) ? 2'b00 : 2'b11)) begin
          n_fail++; $display("FAIL blink tick %0d state: got %b want %b", k, state, (k == 8) ? 2'b00 : 2'b11);
        end
      end
      step();
    end
    n_checks++;
    if (winner !== 2'b00) begin n_fail++; $display("FAIL win exit winner: got %b want 00", winner); end
  endtask

  task automatic test_both_buttons();
    go_play();
    btn_l = 1'b1; btn_r = 1'b1; step(); btn_l = 1'b0; btn_r = 1'b0;
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL both pressed leds: got %h want 010", leds); end
    btn_r = 1'b1; step(); btn_r = 1'b0;
    n_checks++;
    if (leds !== 9'h020) begin n_fail++; $display("FAIL btn_r leds: got %h want 020", leds); end
    // Tick plus press in PLAY: the press still moves the rope.
    slowen = 1'b1; btn_l = 1'b1; step(); slowen = 1'b0; btn_l = 1'b0;
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL slowen+btn_l leds: got %h want 010", leds); end
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (state !== 2'b10 || div_rst !== 1'b0) begin
      n_fail++; $display("FAIL start in play: state %b div_rst %b want 10 0", state, div_rst);
    end
  endtask

  task automatic test_right_win_reset();
    for (int k = 0; k < 4; k++) begin
      btn_r = 1'b1; step(); btn_r = 1'b0;
    end
    n_checks++;
    if (leds !== 9'h100 || state !== 2'b11 || winner !== 2'b10) begin
      n_fail++; $display("FAIL right win: leds %h state %b winner %b want 100 11 10", leds, state, winner);
    end
    slowen = 1'b1; step(); slowen = 1'b0;
    n_checks++;
    if (leds !== 9'h000) begin n_fail++; $display("FAIL right blink leds: got %h want 000", leds); end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (state !== 2'b00 || leds !== 9'h010 || winner !== 2'b00 || div_rst !== 1'b0) begin
      n_fail++; $display("FAIL mid-blink reset: state %b leds %h winner %b div_rst %b want 00 010 00 0",
                         state, leds, winner, div_rst);
    end
  endtask

  task automatic test_false_start();
    start = 1'b1; step(); start = 1'b0;
    step();
    btn_r = 1'b1; step(); btn_r = 1'b0;
`ifdef TOW_FALSE_START_EN
    n_checks++;
    if (leds !== 9'h008) begin n_fail++; $display("FAIL false start btn_r leds: got %h want 008", leds); end
    repeat (4) begin btn_r = 1'b1; step(); btn_r = 1'b0; end
    n_checks++;
    if (leds !== 9'h002) begin n_fail++; $display("FAIL false start clamp leds: got %h want 002", leds); end
    btn_l = 1'b1; step(); btn_l = 1'b0;
    n_checks++;
    if (leds !== 9'h004) begin n_fail++; $display("FAIL false start btn_l leds: got %h want 004", leds); end
`else
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL cntdn btn_r ignored leds: got %h want 010", leds); end
    btn_l = 1'b1; step(); btn_l = 1'b0;
    n_checks++;
    if (leds !== 9'h010) begin n_fail++; $display("FAIL cntdn btn_l ignored leds: got %h want 010", leds); end
`endif
    n_checks++;
    if (state !== 2'b01) begin n_fail++; $display("FAIL false start keeps cntdn: got %b want 01", state); end
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++;
    if (state !== 2'b00 || leds !== 9'h010) begin
      n_fail++; $display("FAIL mid-cntdn reset: state %b leds %h want 00 010", state, leds);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_countdown();
    test_left_win();
    test_both_buttons();
    test_right_win_reset();
    test_false_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
